apb_slave_regfile: RTL and testbench
====================================

# apb_slave_regfile

Parametrised APB completer with an internal word-addressed register file, programmable wait states, byte-lane write strobes and error response. It succeeds the fixed 8-bit APB slave. It sits behind the APB requester/interconnect as a generic peripheral register bank: each `sel` line from the decoder drives one instance.

## Interface
- `DATA_W`, 32: data width in bits; must be a multiple of 8.
- `ADDR_W`, 8: byte-address width.
- `DEPTH`, 16: number of DATA_W-bit registers; must satisfy DEPTH <= 2^(ADDR_W - log2(DATA_W/8)).
- `WAIT_CYCLES`, 0: wait states inserted in every access phase (0..255).

Ports:
- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `sel` in 1: slave select (PSEL).
- `enable` in 1: access phase (PENABLE).
- `w_en` in 1: 1 = write, 0 = read (PWRITE).
- `add` in ADDR_W: byte address (PADDR).
- `data_in` in DATA_W: write data (PWDATA).
- `strb` in DATA_W/8: byte-lane write strobes (PSTRB).
- `ready` out 1: transfer completes this cycle (PREADY).
- `data_out` out DATA_W: read data (PRDATA).
- `slverr` out 1: error response, valid only while `ready`=1 (PSLVERR).

## Operation
- Register index is `add >> log2(DATA_W/8)`. The address is in error if the low log2(DATA_W/8) bits are non-zero (misaligned) or the index >= DEPTH.
- The FSM has two states, IDLE and ACCESS.
- IDLE to ACCESS: on an edge sampling `sel`=1, `enable`=0 (setup phase). At that edge the block:
  - latches `w_en`, `data_in`, `strb`, the index and the error flag;
  - loads the wait counter `cnt` with WAIT_CYCLES;
  - sets `ready` to (WAIT_CYCLES==0) and `slverr` to (error & WAIT_CYCLES==0);
  - for an error-free read, loads `data_out` with mem[index]; for an erroneous read, loads 0; for a write, holds `data_out`.
- In ACCESS with `sel`=1, `enable`=1, `ready`=0: `cnt` decrements each edge. When `cnt`==1, `ready` is set to 1 and `slverr` to the latched error flag.
- Completion: an edge in ACCESS with `sel`=`enable`=`ready`=1. At that edge:
  - an error-free write updates each byte lane i of mem[index] where strb[i]=1;
  - the FSM returns to IDLE and `ready` and `slverr` clear.
- A write with strb all zero completes OKAY and changes nothing. An erroneous write never modifies memory.
- `add`, `data_in` and `strb` changes during ACCESS are ignored, because all values are latched at setup.
- Protocol violations:
  - `sel`=1, `enable`=1 in IDLE with no preceding setup is ignored: no `ready`, no write.
  - `sel`=0 while in ACCESS aborts: go to IDLE, clear `ready`/`slverr`, no write.
  - `enable`=0 while in ACCESS with `sel`=1 is treated as a new setup: restart with fresh latching.
- `data_out` holds its value until the next read setup. It is not cleared after completion.

## Timing
- Reset values: `ready`=0, `slverr`=0, `data_out`=0, all registers 0, FSM IDLE, `cnt`=0. Reset overrides any transfer in progress; `ready` is 0 on the cycle after the reset edge.
- Setup cycle T0, first access cycle T1. `ready`=1 exactly during cycle T1+WAIT_CYCLES and for that one cycle only. Total transfer: 2+WAIT_CYCLES cycles.
- Write data is visible to a read whose setup edge follows the completion edge, i.e. back-to-back write-then-read returns the new data.
- Back-to-back transfers: `sel` may stay high. The setup phase in the cycle after completion is accepted with zero idle cycles.

## Test plan
- Reset: hold `rst`=1 for 3 cycles with `sel`=1, `enable`=1 -> `ready`/`slverr`/`data_out` = 0; a subsequent read of 0x00 returns 0x00000000, `slverr`=0.
- Write/read, WAIT_CYCLES=0: write 0x08 with 0xDEADBEEF, strb=0xF -> `ready` high in T1 only. Read 0x08 -> `data_out`=0xDEADBEEF in T1, `slverr`=0.
- Strobes: after the previous test, write 0x08 with 0x11223344, strb=0x5 -> read 0x08 returns 0xDE22BE44. Write strb=0x0 -> value unchanged, `slverr`=0.
- Errors: read 0x40 (index 16) and 0x09 (misaligned) -> `slverr`=1 with `ready`, `data_out`=0. Write 0x40 -> no register changes; a full readback of 0x00..0x3C is unchanged.
- Wait states, WAIT_CYCLES=3 instance: a write to 0x0C -> `ready` low in T1..T3 and high in T4 only. A read back-to-back with `sel` held high returns the written data, `ready` in its own T4.
- Abort/reset: WAIT_CYCLES=3, drop `sel` in T2 of a write 0x04 0xA5A5A5A5 -> no `ready`, mem[1] unchanged. Assert `rst` in T2 of another write -> `ready`=0 next cycle and mem[1]=0.

Source files
------------

// File: rtl/apb_slave_regfile.sv
// APB completer with a word-addressed register file, programmable wait states,
// byte-lane write strobes and an error response for misaligned or out-of-range addresses.
module apb_slave_regfile #(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 8,
   parameter int DEPTH       = 16,
   parameter int WAIT_CYCLES = 0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                sel,
   input  logic                enable,
   input  logic                w_en,
   input  logic [ADDR_W-1:0]   add,
   input  logic [DATA_W-1:0]   data_in,
   input  logic [DATA_W/8-1:0] strb,
   output logic                ready,
   output logic [DATA_W-1:0]   data_out,
   output logic                slverr,
   output logic                dbg_state
);
   localparam int BYTES = DATA_W / 8;
   localparam int SH    = $clog2(BYTES);
   localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

   state_t              state, state_nxt;
   logic [DATA_W-1:0]   mem [DEPTH];
   logic [7:0]          cnt;
   logic                lat_we, lat_err;
   logic [DATA_W-1:0]   lat_data;
   logic [BYTES-1:0]    lat_strb;
   logic [IW-1:0]       lat_idx;
   logic [ADDR_W-1:0]   idx;
   logic [IW-1:0]       idx_s;
   logic                in_err;
   logic                go_setup, complete, step, leave;

   assign idx       = add >> SH;
   assign idx_s     = idx[IW-1:0];
   assign in_err    = ((add & ADDR_W'(BYTES - 1)) != '0) ||
                      ({1'b0, idx} >= (ADDR_W + 1)'(DEPTH));
   assign dbg_state = state;

   // Valid/ready semantics: a transfer is set up on an edge with sel=1, enable=0 and
   // completes on the edge where sel, enable and ready are all high; nothing else commits.
   always_comb begin
      state_nxt = state;
      go_setup  = 1'b0;
      complete  = 1'b0;
      step      = 1'b0;
      leave     = 1'b0;
      case (state)
         IDLE: begin
            if (sel && !enable) begin
               state_nxt = ACCESS;
               go_setup  = 1'b1;
            end
         end
         ACCESS: begin
            if (!sel) begin
               state_nxt = IDLE;
               leave     = 1'b1;
            end else if (!enable) begin
               go_setup = 1'b1;
            end else if (ready) begin
               state_nxt = IDLE;
               complete  = 1'b1;
               leave     = 1'b1;
            end else begin
               step = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ready    <= 1'b0;
         slverr   <= 1'b0;
         data_out <= '0;
         cnt      <= '0;
         lat_we   <= 1'b0;
         lat_err  <= 1'b0;
         lat_data <= '0;
         lat_strb <= '0;
         lat_idx  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (go_setup) begin
         lat_we   <= w_en;
         lat_err  <= in_err;
         lat_data <= data_in;
         lat_strb <= strb;
         lat_idx  <= idx_s;
         cnt      <= 8'(WAIT_CYCLES);
         ready    <= (WAIT_CYCLES == 0);
         slverr   <= in_err && (WAIT_CYCLES == 0);
         if (!w_en) data_out <= in_err ? '0 : mem[idx_s];
      end else if (leave) begin
         ready  <= 1'b0;
         slverr <= 1'b0;
         if (complete && lat_we && !lat_err) begin
            for (int b = 0; b < BYTES; b++)
               if (lat_strb[b]) mem[lat_idx][8*b +: 8] <= lat_data[8*b +: 8];
         end
      end else if (step) begin
         cnt <= cnt - 8'd1;
         if (cnt == 8'd1) begin
            ready  <= 1'b1;
            slverr <= lat_err;
         end
      end
   end
endmodule

// File: tb/tb_apb_slave_regfile.sv
// Randomized scoreboard bench for two apb_slave_regfile instances (0 and 3 wait states)
// checked against an array-based register model.
module tb_apb_slave_regfile;
   logic        clk = 1'b0;
   logic        rst_v  [2];
   logic        sel_v  [2];
   logic        en_v   [2];
   logic        we_v   [2];
   logic [7:0]  add_v  [2];
   logic [31:0] din_v  [2];
   logic [3:0]  strb_v [2];
   logic        rdy_v  [2];
   logic [31:0] dout_v [2];
   logic        err_v  [2];
   logic        st_v   [2];

   logic [31:0] ref_mem  [2][16];
   logic [31:0] ref_dout [2];
   logic [63:0] exp_q0[$];
   logic [63:0] exp_q1[$];
   int          cyc = 0;
   int          n_checks = 0;
   int          n_pass = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   apb_slave_regfile #(.DATA_W(32), .ADDR_W(8), .DEPTH(16), .WAIT_CYCLES(0)) u_w0 (
      .clk(clk), .rst(rst_v[0]), .sel(sel_v[0]), .enable(en_v[0]), .w_en(we_v[0]),
      .add(add_v[0]), .data_in(din_v[0]), .strb(strb_v[0]), .ready(rdy_v[0]),
      .data_out(dout_v[0]), .slverr(err_v[0]), .dbg_state(st_v[0]));

   apb_slave_regfile #(.DATA_W(32), .ADDR_W(8), .DEPTH(16), .WAIT_CYCLES(3)) u_w3 (
      .clk(clk), .rst(rst_v[1]), .sel(sel_v[1]), .enable(en_v[1]), .w_en(we_v[1]),
      .add(add_v[1]), .data_in(din_v[1]), .strb(strb_v[1]), .ready(rdy_v[1]),
      .data_out(dout_v[1]), .slverr(err_v[1]), .dbg_state(st_v[1]));

   task automatic chk(string name, int k, logic [63:0] act, logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s inst%0d: got %0h expected %0h (cycle %0d)", name, k, act, exp, cyc);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int qsize(int k);
      return (k == 0) ? exp_q0.size() : exp_q1.size();
   endfunction

   function automatic logic [63:0] qpop(int k);
      if (k == 0) return exp_q0.pop_front();
      return exp_q1.pop_front();
   endfunction

   function automatic int qfront_cyc(int k);
      logic [63:0] e;
      e = (k == 0) ? exp_q0[0] : exp_q1[0];
      return int'(e[63:33]);
   endfunction

   // Monitor: every ready pulse must match the oldest expected response, on its cycle.
   always @(negedge clk) begin
      logic [63:0] e;
      for (int k = 0; k < 2; k++) begin
         if (rdy_v[k] === 1'b1) begin
            if (qsize(k) == 0) begin
               chk("unexpected_ready", k, 64'(rdy_v[k]), 64'd0);
            end else begin
               e = qpop(k);
               chk("ready_cycle", k, 64'(cyc), 64'(e[63:33]));
               chk("slverr", k, 64'(err_v[k]), 64'(e[32]));
               chk("data_out", k, 64'(dout_v[k]), 64'(e[31:0]));
            end
         end else if (qsize(k) > 0 && qfront_cyc(k) <= cyc) begin
            e = qpop(k);
            chk("missing_ready", k, 64'(rdy_v[k]), 64'd1);
         end
      end
   end

   // mode: 0 normal, 1 drop sel in T2, 2 reset in T2, 3 leave in T2 for a restart
   task automatic xfer(int k, bit we, logic [7:0] a, logic [31:0] d, logic [3:0] s, int mode);
      int          w;
      int          idx;
      bit          err;
      int          t0;
      logic [63:0] e;
      w   = (k == 0) ? 0 : 3;
      idx = int'(a >> 2);
      err = (a[1:0] != 2'b00) || (idx >= 16);
      sel_v[k] = 1'b1; en_v[k] = 1'b0; we_v[k] = we;
      add_v[k] = a; din_v[k] = d; strb_v[k] = s;
      t0 = cyc;
      if (!we) ref_dout[k] = err ? 32'd0 : ref_mem[k][idx];
      if (mode == 0) begin
         e = {31'(t0 + 1 + w), err, ref_dout[k]};
         if (k == 0) exp_q0.push_back(e); else exp_q1.push_back(e);
      end
      tick();
      en_v[k] = 1'b1;
      add_v[k] = 8'($urandom); din_v[k] = $urandom; strb_v[k] = 4'($urandom);
      if (mode == 0) begin
         repeat (w + 1) tick();
         en_v[k] = 1'b0;
         if (we && !err)
            for (int b = 0; b < 4; b++)
               if (s[b]) ref_mem[k][idx][8*b +: 8] = d[8*b +: 8];
      end else if (mode == 1) begin
         tick();
         sel_v[k] = 1'b0; en_v[k] = 1'b0;
         tick();
      end else if (mode == 2) begin
         tick();
         rst_v[k] = 1'b1;
         tick();
         rst_v[k] = 1'b0; sel_v[k] = 1'b0; en_v[k] = 1'b0;
         for (int i = 0; i < 16; i++) ref_mem[k][i] = 32'd0;
         ref_dout[k] = 32'd0;
         chk("ready_after_rst", k, 64'(rdy_v[k]), 64'd0);
         chk("dout_after_rst", k, 64'(dout_v[k]), 64'd0);
      end else begin
         tick();
      end
   endtask

   task automatic go_idle(int k, int n);
      sel_v[k] = 1'b0; en_v[k] = 1'b0;
      repeat (n) tick();
   endtask

   task automatic readback(int k);
      for (int i = 0; i < 16; i++) xfer(k, 1'b0, 8'(i * 4), 32'd0, 4'h0, 0);
   endtask

   task automatic random_run(int k, int n);
      logic [7:0] a;
      int         r;
      for (int i = 0; i < n; i++) begin
         r = $urandom_range(0, 9);
         if (r <= 6)      a = {4'($urandom_range(0, 15)), 2'b00};
         else if (r == 7) a = {4'($urandom_range(0, 15)), 2'($urandom_range(1, 3))};
         else if (r == 8) a = {2'($urandom_range(1, 3)), 4'($urandom), 2'b00};
         else             a = 8'($urandom);
         xfer(k, 1'($urandom), a, $urandom, 4'($urandom), 0);
         if ($urandom_range(0, 2) == 0) go_idle(k, $urandom_range(1, 3));
      end
   endtask

   initial begin
      for (int k = 0; k < 2; k++) begin
         rst_v[k] = 1'b1; sel_v[k] = 1'b1; en_v[k] = 1'b1; we_v[k] = 1'b1;
         add_v[k] = 8'h08; din_v[k] = 32'hFFFF_FFFF; strb_v[k] = 4'hF;
         ref_dout[k] = 32'd0;
         for (int i = 0; i < 16; i++) ref_mem[k][i] = 32'd0;
      end
      repeat (3) tick();
      for (int k = 0; k < 2; k++) begin
         chk("reset_ready", k, 64'(rdy_v[k]), 64'd0);
         chk("reset_slverr", k, 64'(err_v[k]), 64'd0);
         chk("reset_dout", k, 64'(dout_v[k]), 64'd0);
         rst_v[k] = 1'b0;
         go_idle(k, 0);
      end
      tick();

      // zero wait states: directed then random
      xfer(0, 1'b0, 8'h00, 32'd0, 4'h0, 0);
      xfer(0, 1'b1, 8'h08, 32'hDEAD_BEEF, 4'hF, 0);
      xfer(0, 1'b0, 8'h08, 32'd0, 4'h0, 0);
      xfer(0, 1'b1, 8'h08, 32'h1122_3344, 4'h5, 0);
      xfer(0, 1'b0, 8'h08, 32'd0, 4'h0, 0);
      xfer(0, 1'b1, 8'h08, 32'h0BAD_F00D, 4'h0, 0);
      xfer(0, 1'b0, 8'h08, 32'd0, 4'h0, 0);
      xfer(0, 1'b0, 8'h40, 32'd0, 4'h0, 0);
      xfer(0, 1'b0, 8'h09, 32'd0, 4'h0, 0);
      xfer(0, 1'b1, 8'h40, 32'hFFFF_FFFF, 4'hF, 0);
      go_idle(0, 1);
      readback(0);
      go_idle(0, 1);
      sel_v[0] = 1'b1; en_v[0] = 1'b1; we_v[0] = 1'b1;
      add_v[0] = 8'h08; din_v[0] = 32'h0; strb_v[0] = 4'hF;
      repeat (2) tick();
      go_idle(0, 1);
      xfer(0, 1'b0, 8'h08, 32'd0, 4'h0, 0);
      random_run(0, 60);
      readback(0);
      go_idle(0, 2);

      // three wait states: back-to-back, abort, restart, reset mid-transfer
      xfer(1, 1'b1, 8'h0C, 32'hCAFE_F00D, 4'hF, 0);
      xfer(1, 1'b0, 8'h0C, 32'd0, 4'h0, 0);
      xfer(1, 1'b1, 8'h04, 32'h1234_5678, 4'hF, 0);
      go_idle(1, 1);
      xfer(1, 1'b1, 8'h04, 32'hA5A5_A5A5, 4'hF, 1);
      xfer(1, 1'b0, 8'h04, 32'd0, 4'h0, 0);
      xfer(1, 1'b1, 8'h10, 32'h5555_5555, 4'hF, 3);
      xfer(1, 1'b0, 8'h10, 32'd0, 4'h0, 0);
      xfer(1, 1'b1, 8'h08, 32'h0000_ABCD, 4'h3, 0);
      xfer(1, 1'b1, 8'h04, 32'h7777_7777, 4'hF, 2);
      xfer(1, 1'b0, 8'h04, 32'd0, 4'h0, 0);
      xfer(1, 1'b0, 8'h08, 32'd0, 4'h0, 0);
      xfer(1, 1'b0, 8'h3D, 32'd0, 4'h0, 0);
      random_run(1, 40);
      readback(1);
      go_idle(1, 8);

      for (int k = 0; k < 2; k++) chk("queue_drained", k, 64'(qsize(k)), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
